audio_playback_ctrl: RTL and testbench

Playback sequencer for the UART-fed PCM FIFO → sigma-delta DAC path. Generates the sample-rate FIFO read strobe with a fractional divider, so 44.1 kHz is exact from 12 MHz. Gates playback behind a prefill threshold and detects underruns, holding the DACs in reset while no valid data exists. Drives host flow control with hysteresis, replacing the raw almost-empty/almost-full compares.

---
 rtl/audio_playback_ctrl.sv | 119 +++++++++++
 tb/tb_audio_playback_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_playback_ctrl.sv
// Playback sequencer: fractional sample-rate divider, prefill/underrun FSM and host flow control.
// Optional underrun counter port enabled by AUDIO_PLAYBACK_CTRL_UNDERRUN_CNT_EN.
module audio_playback_ctrl #(
  parameter int CLK_FREQ    = 12_000_000,
  parameter int SAMPLE_FREQ = 44_100,
  parameter int FILL_BITS   = 13,
  parameter int START_LEVEL = 4096,
  parameter int LOW_MARK    = 2048,
  parameter int HIGH_MARK   = 6144
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [FILL_BITS-1:0] fifo_fill,
  input  logic                 fifo_empty,
  input  logic                 fifo_full,
  output logic                 fifo_rd_en,
  output logic                 dac_reset,
  output logic                 host_ready,
  output logic [1:0]           state,
  output logic                 sample_tick
`ifdef AUDIO_PLAYBACK_CTRL_UNDERRUN_CNT_EN
  ,
  output logic [15:0]          underrun_count
`endif
);

  localparam int ACC_W = $clog2(CLK_FREQ) + 1;
  localparam logic [ACC_W-1:0]   CLK_F   = ACC_W'(CLK_FREQ);
  localparam logic [ACC_W-1:0]   SAMP_F  = ACC_W'(SAMPLE_FREQ);
  localparam logic [FILL_BITS:0] START_L = (FILL_BITS + 1)'(START_LEVEL);
  localparam logic [FILL_BITS:0] LOW_L   = (FILL_BITS + 1)'(LOW_MARK);
  localparam logic [FILL_BITS:0] HIGH_L  = (FILL_BITS + 1)'(HIGH_MARK);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFILL  = 2'd1,
    PLAY     = 2'd2,
    UNDERRUN = 2'd3
  } state_t;

  state_t             state_q, state_next;
  logic [ACC_W-1:0]   acc_q, acc_next, sum;
  logic               tick_next;
  logic               rd_next;
  logic               host_next;
  logic [FILL_BITS:0] fill_ext;

  assign fill_ext = {1'b0, fifo_fill};
  assign state    = state_q;

  // Fractional divider: wraps at CLK_FREQ, carrying the remainder into the next period.
  always_comb begin
    sum       = acc_q + SAMP_F;
    tick_next = (sum >= CLK_F);
    acc_next  = tick_next ? (sum - CLK_F) : sum;
  end

  always_comb begin
    state_next = state_q;
    rd_next    = 1'b0;
    case (state_q)
      IDLE:     if (enable) state_next = PREFILL;
      PREFILL:  if ((fill_ext >= START_L) || fifo_full) state_next = PLAY;
      PLAY: begin
        if (sample_tick) begin
          if (fifo_empty) state_next = UNDERRUN;
          else            rd_next    = 1'b1;
        end
      end
      UNDERRUN: state_next = PREFILL;
      default:  state_next = IDLE;
    endcase
    // Disable overrides everything, including a read requested on this tick.
    if (!enable) begin
      state_next = IDLE;
      rd_next    = 1'b0;
    end
  end

  always_comb begin
    host_next = host_ready;
    if (fifo_full || (fill_ext >= HIGH_L)) host_next = 1'b0;
    else if (fill_ext <= LOW_L)            host_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      sample_tick <= 1'b0;
      fifo_rd_en  <= 1'b0;
      dac_reset   <= 1'b1;
      host_ready  <= 1'b1;
    end else begin
      state_q     <= state_next;
      acc_q       <= acc_next;
      sample_tick <= tick_next;
      fifo_rd_en  <= rd_next;
      dac_reset   <= (state_next != PLAY);
      host_ready  <= host_next;
    end
  end

`ifdef AUDIO_PLAYBACK_CTRL_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_cnt_q <= '0;
    end else if ((state_q == PLAY) && (state_next == UNDERRUN) && (underrun_cnt_q != '1)) begin
      underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  assign underrun_count = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_audio_playback_ctrl.sv
// Scoreboard bench for audio_playback_ctrl: stimulus pushes expectations, a negedge monitor checks them.
module tb_audio_playback_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [12:0] fifo_fill = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_full = 1'b0;

  logic       d1_rd, d1_dac, d1_host, d1_tick;
  logic [1:0] d1_state;
  logic       d2_rd, d2_dac, d2_host, d2_tick;
  logic [1:0] d2_state;
`ifdef AUDIO_PLAYBACK_CTRL_UNDERRUN_CNT_EN
  logic [15:0] d1_ucnt, d2_ucnt;
`endif

  audio_playback_ctrl #(
    .CLK_FREQ(100), .SAMPLE_FREQ(10), .FILL_BITS(13),
    .START_LEVEL(8), .LOW_MARK(2048), .HIGH_MARK(6144)
  ) d1 (
    .clk(clk), .reset(reset), .enable(enable), .fifo_fill(fifo_fill),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_rd_en(d1_rd),
    .dac_reset(d1_dac), .host_ready(d1_host), .state(d1_state), .sample_tick(d1_tick)
`ifdef AUDIO_PLAYBACK_CTRL_UNDERRUN_CNT_EN
    , .underrun_count(d1_ucnt)
`endif
  );

  audio_playback_ctrl #(
    .CLK_FREQ(100), .SAMPLE_FREQ(30), .FILL_BITS(13),
    .START_LEVEL(8), .LOW_MARK(2048), .HIGH_MARK(6144)
  ) d2 (
    .clk(clk), .reset(reset), .enable(enable), .fifo_fill(fifo_fill),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_rd_en(d2_rd),
    .dac_reset(d2_dac), .host_ready(d2_host), .state(d2_state), .sample_tick(d2_tick)
`ifdef AUDIO_PLAYBACK_CTRL_UNDERRUN_CNT_EN
    , .underrun_count(d2_ucnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  // mask bits: 0 state, 1 dac_reset, 2 host_ready, 3 sample_tick, 4 fifo_rd_en
  typedef struct {
    string      name;
    logic [1:0] st;
    logic       dac;
    logic       host;
    logic       tick;
    logic       rd;
    logic [4:0] mask;
  } exp_t;

  exp_t expq[$];
  int   rdq[$];

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) n = 0;
    else       n++;
    #1;
  endtask

  task automatic expect_out(input string name, input logic [1:0] st, input logic dac,
                            input logic host, input logic tick, input logic rd,
                            input logic [4:0] mask);
    exp_t e;
    e.name = name; e.st = st; e.dac = dac; e.host = host;
    e.tick = tick; e.rd = rd; e.mask = mask;
    expq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      if (e.mask[0]) chk({e.name, "_state"}, int'(d1_state), int'(e.st));
      if (e.mask[1]) chk({e.name, "_dac_reset"}, int'(d1_dac), int'(e.dac));
      if (e.mask[2]) chk({e.name, "_host_ready"}, int'(d1_host), int'(e.host));
      if (e.mask[3]) chk({e.name, "_sample_tick"}, int'(d1_tick), int'(e.tick));
      if (e.mask[4]) chk({e.name, "_fifo_rd_en"}, int'(d1_rd), int'(e.rd));
    end
    if (!reset && rdq.size() > 0 && rdq[0] == n) begin
      chk("rd_en_expected", int'(d1_rd), 1);
      void'(rdq.pop_front());
    end else if (d1_rd) begin
      chk("rd_en_unexpected", int'(d1_rd), 0);
    end
  end

  initial begin
    int c1, c2, last1, last2, first1, first2, badgap1, badgap2;
    int hf[13];
    logic hfull[13];
    logic hexp[13];
    hf    = '{0, 2048, 4000, 6143, 6144, 6000, 4000, 2049, 2048, 5000, 0, 3000, 2048};
    hfull = '{0, 0,    0,    0,    0,    0,    0,    0,    0,    0,    1, 0,    0};
    hexp  = '{1, 1,    1,    1,    0,    0,    0,    0,    1,    1,    0, 0,    1};

    // Reset
    reset = 1'b1;
    step();
    step();
    expect_out("reset", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b11111);

    // Divider: 1000 cycles in IDLE
    reset = 1'b0;
    c1 = 0; c2 = 0; last1 = 0; last2 = 0; first1 = 0; first2 = 0; badgap1 = 0; badgap2 = 0;
    repeat (1000) begin
      step();
      if (d1_tick) begin
        if (last1 == 0) first1 = n;
        else if (n - last1 != 10) badgap1++;
        last1 = n;
        c1++;
      end
      if (d2_tick) begin
        if (last2 == 0) first2 = n;
        else if ((n - last2 != 3) && (n - last2 != 4)) badgap2++;
        last2 = n;
        c2++;
      end
    end
    chk("div10_count", c1, 100);
    chk("div10_first", first1, 10);
    chk("div10_bad_gaps", badgap1, 0);
    chk("div30_count", c2, 300);
    chk("div30_first", first2, 4);
    chk("div30_bad_gaps", badgap2, 0);

    // Threshold met with enable low: stay IDLE
    fifo_fill = 13'd100; fifo_empty = 1'b0;
    step();
    expect_out("idle_hold", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b10011);

    // Prefill
    enable = 1'b1; fifo_fill = '0; fifo_empty = 1'b1;
    step();
    expect_out("enter_prefill", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b10011);
    for (int f = 0; f < 8; f++) begin
      fifo_fill = 13'(f); fifo_empty = (f == 0);
      step();
      expect_out("prefill_low", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b10011);
    end
    fifo_fill = 13'd8; fifo_empty = 1'b0;
    rdq.push_back(1021);
    rdq.push_back(1031);
    step();
    expect_out("prefill_hit", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10011);
    while (n < 1040) begin
      step();
      expect_out("play", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00011);
    end

    // Underrun at the tick after edge 1040
    fifo_fill = '0; fifo_empty = 1'b1;
    step();
    expect_out("underrun", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5'b10011);
`ifdef AUDIO_PLAYBACK_CTRL_UNDERRUN_CNT_EN
    chk("underrun_count", int'(d1_ucnt), 1);
`endif
    step();
    expect_out("post_underrun", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b10011);
    step();
    expect_out("refill_wait", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b10011);

    // Enable drop coincident with a tick in PLAY
    fifo_fill = 13'd8; fifo_empty = 1'b0;
    step();
    expect_out("replay", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10011);
    while (n < 1050) begin
      step();
      expect_out("play2", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00011);
    end
    enable = 1'b0;
    step();
    expect_out("enable_drop", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b10011);

    // Reset mid-PLAY with a read pending
    enable = 1'b1;
    step();
    expect_out("reprefill", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00011);
    step();
    expect_out("play3", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00011);
    fifo_fill = 13'd7000;
    while (n < 1060) begin
      step();
      expect_out("play3", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00011);
    end
    expect_out("host_high_in_play", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 5'b01000);
    reset = 1'b1;
    step();
    expect_out("mid_reset", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b11111);

    // Accumulator restarts from 0: first tick after the 10th edge
    reset = 1'b0; enable = 1'b0; fifo_fill = '0; fifo_empty = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      expect_out("acc_restart", 2'd0, 1'b1, 1'b1, (k == 10), 1'b0, 5'b01000);
    end

    // host_ready hysteresis
    for (int i = 0; i < 13; i++) begin
      fifo_fill = 13'(hf[i]); fifo_full = hfull[i];
      step();
      expect_out("hysteresis", 2'd0, 1'b1, hexp[i], 1'b0, 1'b0, 5'b00100);
    end
    fifo_full = 1'b0;

    step();
    @(negedge clk);
    #1;
    chk("rd_pending", rdq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
